// File: rtl/dffram_bist_pkg.sv
// Shared types for the DFFRAM March C- BIST: FSM states, data patterns and
// the per-element drive/compare table.
package dffram_bist_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_M0,
        ST_M1,
        ST_M2,
        ST_M3,
        ST_M4,
        ST_M5,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [31:0] P0 = 32'h0000_0000;
    localparam logic [31:0] P1 = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        march;    // state drives the RAM
        logic        down;     // walks N-1 down to 0
        logic        rd;       // RAM data is compared next cycle
        logic        wr;       // full-word write this cycle
        logic [31:0] exp_pat;
        logic [31:0] wr_pat;
    } elem_t;

    function automatic elem_t elem_of(input state_t s);
        elem_t e;
        e = '0;
        case (s)
            ST_M0: begin
                e.march = 1'b1; e.wr = 1'b1; e.wr_pat = P0;
            end
            ST_M1: begin
                e.march = 1'b1; e.rd = 1'b1; e.wr = 1'b1;
                e.exp_pat = P0; e.wr_pat = P1;
            end
            ST_M2: begin
                e.march = 1'b1; e.rd = 1'b1; e.wr = 1'b1;
                e.exp_pat = P1; e.wr_pat = P0;
            end
            ST_M3: begin
                e.march = 1'b1; e.down = 1'b1; e.rd = 1'b1; e.wr = 1'b1;
                e.exp_pat = P0; e.wr_pat = P1;
            end
            ST_M4: begin
                e.march = 1'b1; e.down = 1'b1; e.rd = 1'b1; e.wr = 1'b1;
                e.exp_pat = P1; e.wr_pat = P0;
            end
            ST_M5: begin
                e.march = 1'b1; e.rd = 1'b1; e.exp_pat = P0;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic state_t next_elem(input state_t s);
        state_t n;
        case (s)
            ST_M0:   n = ST_M1;
            ST_M1:   n = ST_M2;
            ST_M2:   n = ST_M3;
            ST_M3:   n = ST_M4;
            ST_M4:   n = ST_M5;
            ST_M5:   n = ST_DRAIN;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

    function automatic logic starts_down(input state_t s);
        elem_t e;
        e = elem_of(s);
        return e.down;
    endfunction

endpackage

// File: rtl/dffram_march_bist_if.sv
// RAM port owned by the BIST: master drives EN/WE/A/Di, the RAM returns Do.
// Do is registered in the RAM and valid the cycle after EN; it reads 0 when EN was low.
interface dffram_march_bist_if #(
    parameter int AW = 8
);
    logic          ram_EN;
    logic [3:0]    ram_WE;
    logic [AW-1:0] ram_A;
    logic [31:0]   ram_Di;
    logic [31:0]   ram_Do;

    modport master (
        output ram_EN,
        output ram_WE,
        output ram_A,
        output ram_Di,
        input  ram_Do
    );

    modport slave (
        input  ram_EN,
        input  ram_WE,
        input  ram_A,
        input  ram_Di,
        output ram_Do
    );
endinterface

// File: rtl/dffram_bist_cmp.sv
// Registered read-compare stage with sticky first-failure capture.
// Read context is registered with the RAM access and compared against Do one cycle later.
module dffram_bist_cmp #(
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_rd_vld,
    input  logic [31:0]   i_exp,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_do,
    output logic          o_fail,
    output logic [AW-1:0] o_fail_addr,
    output logic [31:0]   o_fail_syn
);

    logic          r_rd_vld;
    logic [31:0]   r_exp;
    logic [AW-1:0] r_addr;
    logic          r_fail;
    logic [AW-1:0] r_fail_addr;
    logic [31:0]   r_fail_syn;

    logic [31:0]   w_syn;
    logic          w_mis;

    assign w_syn = i_do ^ r_exp;
    assign w_mis = r_rd_vld && (w_syn != 32'h0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_vld    <= 1'b0;
            r_exp       <= '0;
            r_addr      <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_syn  <= '0;
        end else begin
            r_rd_vld <= i_rd_vld;
            r_exp    <= i_exp;
            r_addr   <= i_addr;
            if (i_clr) begin
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_syn  <= '0;
            end else if (w_mis && !r_fail) begin
                // only the first mismatch of a run is kept
                r_fail      <= 1'b1;
                r_fail_addr <= r_addr;
                r_fail_syn  <= w_syn;
            end
        end
    end

    assign o_fail      = r_fail;
    assign o_fail_addr = r_fail_addr;
    assign o_fail_syn  = r_fail_syn;

endmodule

// File: rtl/dffram_march_bist.sv
// March C- BIST initiator for a DFFRAM instance: element FSM, up/down address
// counter and RAM-port decode; reads are checked by dffram_bist_cmp.
module dffram_march_bist
    import dffram_bist_pkg::*;
#(
    parameter int COLS = 1,
    parameter int AW   = 8 + $clog2(COLS)   // derived from COLS, leave at default
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [AW-1:0] fail_addr,
    output logic [31:0]   fail_syn,
    output state_t        o_dbg_state,
    dffram_march_bist_if.master ram
);

    localparam logic [AW-1:0] LAST = AW'(256 * COLS - 1);

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic          r_busy;
    logic          r_done;

    elem_t         w_el;
    logic          w_last;
    logic          w_start;

    assign w_el    = elem_of(r_state);
    assign w_last  = w_el.down ? (r_addr == '0) : (r_addr == LAST);
    assign w_start = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_M0;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    // element hand-off is bubble-free: next element's first address follows directly
                    if (w_last) begin
                        r_state <= next_elem(r_state);
                        r_addr  <= starts_down(next_elem(r_state)) ? LAST : '0;
                    end else if (w_el.down) begin
                        r_addr  <= r_addr - AW'(1);
                    end else begin
                        r_addr  <= r_addr + AW'(1);
                    end
                end
            endcase
        end
    end

    assign ram.ram_EN = w_el.march;
    assign ram.ram_WE = w_el.wr ? 4'hF : 4'h0;
    assign ram.ram_A  = w_el.march ? r_addr : '0;
    assign ram.ram_Di = w_el.wr ? w_el.wr_pat : 32'h0;

    dffram_bist_cmp #(
        .AW (AW)
    ) u_cmp (
        .i_clk       (CLK),
        .i_rst_n     (RESETn),
        .i_clr       (w_start),
        .i_rd_vld    (w_el.rd),
        .i_exp       (w_el.exp_pat),
        .i_addr      (r_addr),
        .i_do        (ram.ram_Do),
        .o_fail      (fail),
        .o_fail_addr (fail_addr),
        .o_fail_syn  (fail_syn)
    );

    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dffram_march_bist.sv
// Bench for dffram_march_bist: COLS=1 and COLS=2 instances, each beside a
// read-before-write RAM model with an optional stuck-at-1 fault.
module tb_dffram_march_bist;
    import dffram_bist_pkg::*;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;

    logic        busy1, done1, fail1;
    logic [7:0]  fail_addr1;
    logic [31:0] fail_syn1;
    state_t      dbg1;
    logic        busy2, done2, fail2;
    logic [8:0]  fail_addr2;
    logic [31:0] fail_syn2;
    state_t      dbg2;

    dffram_march_bist_if #(.AW(8)) bus1 ();
    dffram_march_bist_if #(.AW(9)) bus2 ();

    dffram_march_bist #(.COLS(1)) u_dut1 (
        .CLK (CLK), .RESETn (RESETn), .start (start1),
        .busy (busy1), .done (done1), .fail (fail1),
        .fail_addr (fail_addr1), .fail_syn (fail_syn1),
        .o_dbg_state (dbg1), .ram (bus1)
    );

    dffram_march_bist #(.COLS(2)) u_dut2 (
        .CLK (CLK), .RESETn (RESETn), .start (start2),
        .busy (busy2), .done (done2), .fail (fail2),
        .fail_addr (fail_addr2), .fail_syn (fail_syn2),
        .o_dbg_state (dbg2), .ram (bus2)
    );

    always #5 CLK = ~CLK;

    // RAM models
    localparam logic [7:0]  FAULT_ADDR = 8'h2A;
    localparam logic [31:0] FAULT_MASK = 32'h0000_0020;
    logic [31:0] mem1 [256];
    logic [31:0] mem2 [512];
    bit          fault_en = 1'b0;

    always @(posedge CLK) begin
        if (bus1.ram_EN) begin
            bus1.ram_Do <= mem1[bus1.ram_A] |
                           ((fault_en && bus1.ram_A == FAULT_ADDR) ? FAULT_MASK : 32'h0);
            for (int b = 0; b < 4; b++)
                if (bus1.ram_WE[b]) mem1[bus1.ram_A][8*b +: 8] <= bus1.ram_Di[8*b +: 8];
        end else begin
            bus1.ram_Do <= 32'h0;
        end
    end

    always @(posedge CLK) begin
        if (bus2.ram_EN) begin
            bus2.ram_Do <= mem2[bus2.ram_A];
            for (int b = 0; b < 4; b++)
                if (bus2.ram_WE[b]) mem2[bus2.ram_A][8*b +: 8] <= bus2.ram_Di[8*b +: 8];
        end else begin
            bus2.ram_Do <= 32'h0;
        end
    end

    // scoreboard
    int          n_checks = 0;
    int          n_errors = 0;
    logic [45:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // {EN, WE, A(9b), Di}
    function automatic logic [45:0] port_word(input int sel);
        if (sel == 1) return {bus1.ram_EN, bus1.ram_WE, 1'b0, bus1.ram_A, bus1.ram_Di};
        return {bus2.ram_EN, bus2.ram_WE, bus2.ram_A, bus2.ram_Di};
    endfunction

    // {fail, fail_addr(9b), fail_syn}
    function automatic logic [41:0] status_word(input int sel);
        if (sel == 1) return {fail1, 1'b0, fail_addr1, fail_syn1};
        return {fail2, fail_addr2, fail_syn2};
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 1) ? busy1 : busy2;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 1) ? done1 : done2;
    endfunction

    function automatic logic get_fail(input int sel);
        return (sel == 1) ? fail1 : fail2;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) start1 = v;
        else          start2 = v;
    endtask

    // March C- drive table: element e, step j, N words
    function automatic logic [45:0] exp_word(input int e, input int j, input int n);
        logic [8:0] a;
        a = (e == 3 || e == 4) ? 9'(n - 1 - j) : 9'(j);
        case (e)
            0:       return {1'b1, 4'hF, a, 32'h0000_0000};
            1:       return {1'b1, 4'hF, a, 32'hFFFF_FFFF};
            2:       return {1'b1, 4'hF, a, 32'h0000_0000};
            3:       return {1'b1, 4'hF, a, 32'hFFFF_FFFF};
            4:       return {1'b1, 4'hF, a, 32'h0000_0000};
            default: return {1'b1, 4'h0, a, 32'h0000_0000};
        endcase
    endfunction

    // One run from a start pulse; abort_at >= 0 returns early at that busy cycle.
    task automatic run_march(input int sel, input bit hold, input int abort_at,
                             input int exp_fail_cycle, input bit exp_fail);
        int n;
        int cycles;
        int fail_seen;
        int k;
        n = (sel == 1) ? 256 : 512;
        cycles = 0;
        fail_seen = -1;
        exp_q.delete();
        for (int e = 0; e < 6; e++)
            for (int j = 0; j < n; j++)
                exp_q.push_back(exp_word(e, j, n));
        exp_q.push_back(46'h0);

        @(negedge CLK);
        set_start(sel, 1'b1);
        @(negedge CLK);
        if (!hold) set_start(sel, 1'b0);
        chk("start_busy", 64'(get_busy(sel)), 64'd1);
        chk("start_clears_fail", 64'(status_word(sel)), 64'd0);
        chk("start_clears_done", 64'(get_done(sel)), 64'd0);

        while (get_busy(sel) && cycles < 8000) begin
            if (abort_at >= 0 && cycles == abort_at) break;
            if (cycles == 3 * n) chk("m3_start_addr", 64'(port_word(sel)[40:32]), 64'(n - 1));
            if (exp_q.size() > 0) chk("seq", 64'(port_word(sel)), 64'(exp_q.pop_front()));
            if (fail_seen < 0 && get_fail(sel)) fail_seen = cycles;
            cycles++;
            @(negedge CLK);
        end

        if (abort_at >= 0) begin
            exp_q.delete();
            chk("abort_reached", 64'(cycles), 64'(abort_at));
        end else begin
            chk("busy_cycles", 64'(cycles), 64'(6 * n + 1));
            chk("seq_left", 64'(exp_q.size()), 64'd0);
            chk("done_set", 64'(get_done(sel)), 64'd1);
            chk("idle_port", 64'(port_word(sel)), 64'd0);
            chk("end_fail", 64'(get_fail(sel)), 64'(exp_fail));
            if (exp_fail_cycle >= 0)
                chk("fail_timing", 64'(fail_seen), 64'(exp_fail_cycle));
            if (hold) begin
                @(negedge CLK);
                chk("restart_busy", 64'(get_busy(sel)), 64'd1);
                chk("restart_done", 64'(get_done(sel)), 64'd0);
                chk("restart_fail", 64'(get_fail(sel)), 64'd0);
                chk("restart_port", 64'(port_word(sel)), 64'(exp_word(0, 0, n)));
                set_start(sel, 1'b0);
                k = 0;
                while (!get_done(sel) && k < 8000) begin
                    k++;
                    @(negedge CLK);
                end
                chk("rerun_done", 64'(get_done(sel)), 64'd1);
            end
        end
    endtask

    initial begin
        // reset
        RESETn = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_busy1", 64'(busy1), 64'd0);
        chk("rst_done1", 64'(done1), 64'd0);
        chk("rst_status1", 64'(status_word(1)), 64'd0);
        chk("rst_port1", 64'(port_word(1)), 64'd0);
        chk("rst_state1", 64'(dbg1), 64'(ST_IDLE));
        chk("rst_busy2", 64'(busy2), 64'd0);
        chk("rst_status2", 64'(status_word(2)), 64'd0);
        chk("rst_port2", 64'(port_word(2)), 64'd0);
        RESETn = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle_no_start", 64'(busy1), 64'd0);

        // fault-free COLS=1
        run_march(1, 1'b0, -1, -1, 1'b0);

        // stuck-at-1 on bit 5 of word 0x2A, first seen in M1
        fault_en = 1'b1;
        run_march(1, 1'b0, -1, 256 + 32'h2A + 2, 1'b1);
        chk("fault_addr", 64'(fail_addr1), 64'h2A);
        chk("fault_syn", 64'(fail_syn1), 64'h20);

        // repaired RAM, start held through the run and into a restart
        fault_en = 1'b0;
        run_march(1, 1'b1, -1, -1, 1'b0);

        // COLS=2
        run_march(2, 1'b0, -1, -1, 1'b0);

        // reset in the middle of M3
        run_march(1, 1'b0, 3 * 256 + 10, -1, 1'b0);
        chk("abort_in_m3", 64'(dbg1), 64'(ST_M3));
        RESETn = 1'b0;
        @(negedge CLK);
        chk("midrst_busy", 64'(busy1), 64'd0);
        chk("midrst_done", 64'(done1), 64'd0);
        chk("midrst_status", 64'(status_word(1)), 64'd0);
        chk("midrst_port", 64'(port_word(1)), 64'd0);
        chk("midrst_state", 64'(dbg1), 64'(ST_IDLE));
        RESETn = 1'b1;
        repeat (2) @(negedge CLK);
        chk("midrst_no_resume", 64'(busy1), 64'd0);
        run_march(1, 1'b0, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dffram_march_bist.md
# dffram_march_bist

Built-in self-test initiator for the `DFFRAM` word-addressed SRAM. It owns the RAM's CLK/EN/WE/A/Di port and checks `Do`. On a start pulse it runs a March C- sequence over every word, compares each read one cycle later, and reports pass/fail with the first failing address and bit syndrome. The block sits beside each DFFRAM instance in the management SoC; the SoC muxes the RAM port between this block and the bus when `busy` is low.

## Interface
- `COLS`, 1, number of 256-word columns; N = 256*COLS words; `AW` = 8+$clog2(COLS)
- `CLK`  in  1  clock; the same clock drives the RAM
- `RESETn`  in  1  reset; synchronous, active-low
- `start`  in  1  level-sampled; begins a run when sampled high in IDLE or DONE
- `busy`  out  1  high while a run is in progress
- `done`  out  1  high from run completion until the next start or reset
- `fail`  out  1  sticky; a mismatch was seen in the current or last run
- `fail_addr`  out  AW  address of the first mismatch
- `fail_syn`  out  32  `Do ^ expected` at the first mismatch
- `ram_EN`  out  1  RAM enable
- `ram_WE`  out  4  RAM byte write enables
- `ram_A`  out  AW  RAM address
- `ram_Di`  out  32  RAM write data
- `ram_Do`  in  32  RAM read data; registered in the RAM, valid the cycle after `ram_EN`

## Operation
- States: IDLE, M0..M5, DRAIN, DONE.
- Patterns: P0 = 32'h0000_0000, P1 = 32'hFFFF_FFFF.
- March elements, one address per cycle:
  - M0 ⇑ w0.
  - M1 ⇑ (r0,w1).
  - M2 ⇑ (r1,w0).
  - M3 ⇓ (r0,w1).
  - M4 ⇓ (r1,w0).
  - M5 ⇑ r0.
- ⇑ means addresses 0 to N-1; ⇓ means N-1 to 0.
- A (r,w) pair is a single RAM cycle: EN=1, WE=4'hF, Di = new pattern. The RAM is read-before-write, so the next-cycle `Do` returns the old value.
- Drive values per element:
  - M0: EN=1, WE=4'hF, Di=P0, no compare.
  - M5: EN=1, WE=0, Di=0.
  - IDLE, DRAIN, DONE: EN=0, WE=0, A=0, Di=0.
- Compare pipeline: on each read cycle, register `rd_vld`, the expected pattern and the address. On the following cycle, compare `ram_Do` with the expected value. Samples with `rd_vld`=0 are never compared, because `Do` is forced to 0 when EN is low.
- The first mismatch sets `fail` and captures `fail_addr` and `fail_syn`. Later mismatches do not overwrite them. The run continues to completion; there is no stop-on-fail.
- Transitions:
  - IDLE or DONE with `start`=1 goes to M0 with the address counter at 0. This also clears `done`, `fail`, `fail_addr` and `fail_syn`.
  - Each element ends on its last address. The next element starts on the following cycle at its own start address, with no bubble.
  - M5 goes to DRAIN for one cycle (the final compare), then to DONE.
- `start` is ignored while `busy`=1.
- All `ram_*` outputs are decoded from the state and counter registers. There is no combinational path from `start` or `ram_Do` to any output.

## Timing
- Reset values: `busy`=0, `done`=0, `fail`=0, `fail_addr`=0, `fail_syn`=0, `ram_EN`=0, `ram_WE`=0, `ram_A`=0, `ram_Di`=0; state IDLE.
- Edge k samples `start`. `busy`=1 and M0 with `ram_A`=0 appear in the cycle after edge k.
- `busy` stays high for exactly 6N+1 cycles (6N march cycles plus DRAIN). After that, `done`=1 and `busy`=0. This is 1537 cycles for COLS=1 and 3073 for COLS=2.
- Compare latency is 1 cycle, so a mismatch is visible on `fail` 2 cycles after the read address is driven.
- `RESETn` low at any point, mid-run included, forces every output to its reset value on the next edge. The RAM contents are then undefined. The run does not resume.
- Element boundaries: the ⇓ elements start at N-1. The counter never wraps: the element advances instead.

## Structure
- Package `dffram_bist_pkg`:
  - state enum (IDLE, M0..M5, DRAIN, DONE);
  - P0/P1 constants;
  - a per-element table of direction, read-enable, expected pattern and write pattern.
- One natural sub-module, `dffram_bist_cmp`: the registered compare stage plus the first-fail capture.
- Top: FSM, the up/down address counter, and the RAM-port decode.

## Test plan
- Fault-free behavioural RAM, COLS=1, one start pulse:
  - `busy` high for exactly 1537 cycles, then `done`=1, `fail`=0.
  - Address sequence and WE/Di match the march table.
- Stuck-at-1 on bit 5 of word 0x2A, injected in the RAM model:
  - `fail`=1, `fail_addr`=0x2A, `fail_syn`=32'h0000_0020 (first detected in M1).
  - `done` still asserts at cycle 1537.
- COLS=2, fault-free:
  - `busy` high for 3073 cycles.
  - `ram_A` spans 0..511; M3 begins at 511.
- `start` held high throughout a run:
  - No restart while `busy`.
  - After DONE, the next cycle restarts with `done` and `fail` cleared.
- `RESETn` pulled low during M3:
  - All outputs at their reset values after the next edge; `ram_EN`=0.
  - A subsequent start runs cleanly to `done`.
- Run with a fault, then repair the model and start again:
  - `fail`, `fail_addr` and `fail_syn` clear to 0 on start.
  - The second run ends with `fail`=0.
